if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port ibus  i_instbus.master  --  ce (chip_en_t), addr (inst_addr_t) out; data (inst_data_t) in; slave returns data combinationally in the same cycle.
REQ-004 SHALL have port stall_i  input  1  hold PC and IF/ID register.
REQ-005 SHALL have port branch_i  input  1  redirect from ID; delay-slot semantics.
REQ-006 SHALL have port branch_target_i  input  32  branch destination.
REQ-007 SHALL have port flush_i  input  1  exception redirect; kills the fetched instruction.
REQ-008 SHALL have port flush_pc_i  input  32  exception handler address.
REQ-009 SHALL have port id_pc_o  output  32  PC of the instruction presented to ID.
REQ-010 SHALL have port id_inst_o  output  32  instruction word presented to ID.
REQ-011 SHALL have port id_valid_o  output  1  id_inst_o is a real fetched instruction.
REQ-012 SHALL have port id_adel_o  output  1  fetch address misaligned (addr[1:0] != 0).

Function
REQ-013 SHALL hold pc register; ibus.addr = pc; ibus.ce = fetch_en register.
REQ-014 SHALL deassert fetch_en during reset and set fetch_en=1 on the first clock after rst falls.
REQ-015 SHALL update pc with priority: flush_i > stall_i > branch_i > sequential (pc+4, wraps modulo 2^32).
REQ-016 SHALL, on flush_i: pc <= flush_pc_i; IF/ID <= bubble (inst=NOP_INST, valid=0, adel=0, pc=0).
REQ-017 SHALL, on stall_i without flush: hold pc and all IF/ID outputs unchanged; ibus.addr stays stable.
REQ-018 SHALL, on branch_i without stall/flush: pc <= branch_target_i; IF/ID captures current fetch (delay slot), not a bubble.
REQ-019 SHALL, sequentially: IF/ID <= {pc, ibus.data, valid=fetch_en}, pc <= pc+4 when fetch_en=1.
REQ-020 SHALL, when pc[1:0] != 0: drive ibus.ce=0, capture inst=NOP_INST, valid=1, adel=1; pc continues advancing until flushed.
REQ-021 SHALL ignore branch_i while stall_i=1 (ID holds its branch request until released).
REQ-022 SHALL make latency one cycle: address issued in cycle N appears on id_* in cycle N+1.

Reset
REQ-023 SHALL, while rst=1: pc=PC_RESET_VEC (0xBFC0_0000), ibus.ce=0, id_pc_o=0, id_inst_o=NOP_INST (0x0000_0000), id_valid_o=0, id_adel_o=0.
REQ-024 SHALL give rst priority over flush_i, stall_i, branch_i; rst mid-stall or mid-branch discards all pending state.

Structure
REQ-025 SHALL take inst_addr_t, inst_data_t, chip_en_t, PC_RESET_VEC, NOP_INST, INST_STEP (4) from package project_types.
REQ-026 SHALL contain one sub-module pc_reg (pc + fetch_en, priority mux); IF/ID register in the top.
REQ-027 SHALL contain no combinational path from ibus.data to ibus.addr or ibus.ce.

Verification
REQ-028 Reset release: rst 1->0 -> cycle 1: ibus.ce=1, addr=0xBFC0_0000; cycle 2: id_pc_o=0xBFC0_0000, id_valid_o=1, addr=0xBFC0_0004.
REQ-029 Stall: stall_i=1 for 3 cycles at pc=0xBFC0_0008 -> addr and id_* frozen for 3 cycles; resumes at 0xBFC0_000C.
REQ-030 Branch + delay slot: branch_i=1, target=0xBFC0_0100 at pc=0xBFC0_0010 -> next id_pc_o=0xBFC0_0010 (valid=1), then 0xBFC0_0100.
REQ-031 Flush/stall/branch same cycle: flush_pc_i=0xBFC0_0380 -> addr=0xBFC0_0380, id_valid_o=0, id_inst_o=0.
REQ-032 Misaligned target 0xBFC0_0102 -> ibus.ce=0; next cycle id_adel_o=1, id_inst_o=0, id_pc_o=0xBFC0_0102.
REQ-033 Wrap: flush_pc_i=0xFFFF_FFFC -> following fetch addr=0x0000_0000; rst asserted during stall -> all outputs to reset values next edge.

Source files
------------

// File: rtl/project_types.sv
// Shared fetch-path types and constants for the IF stage.
package project_types;

  typedef logic [31:0] inst_addr_t;
  typedef logic [31:0] inst_data_t;
  typedef logic        chip_en_t;

  localparam inst_addr_t PC_RESET_VEC = 32'hBFC0_0000;
  localparam inst_data_t NOP_INST     = 32'h0000_0000;
  localparam inst_addr_t INST_STEP    = 32'd4;

  // Contents of the IF/ID pipeline register.
  typedef struct packed {
    inst_addr_t pc;
    inst_data_t inst;
    logic       valid;
    logic       adel;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{pc: '0, inst: NOP_INST, valid: 1'b0, adel: 1'b0};

  // Instruction fetches must be word aligned.
  function automatic logic is_misaligned(input inst_addr_t addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/i_instbus.sv
// Instruction bus: master drives ce/addr, slave returns data in the same cycle.
interface i_instbus;
  import project_types::*;

  chip_en_t   ce;
  inst_addr_t addr;
  inst_data_t data;

  modport master (output ce, output addr, input data);
  modport slave  (input ce, input addr, output data);
endinterface

// File: rtl/pc_reg.sv
// Program counter and fetch-enable register with redirect priority.
module pc_reg
  import project_types::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_stall,
  input  logic       i_branch,
  input  inst_addr_t i_branch_target,
  input  logic       i_flush,
  input  inst_addr_t i_flush_pc,
  output inst_addr_t o_pc,
  output logic       o_fetch_en
);

  inst_addr_t r_pc;
  logic       r_fetch_en;

  // PC update: reset > flush > stall > branch > sequential step.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc       <= PC_RESET_VEC;
      r_fetch_en <= 1'b0;
    end else begin
      r_fetch_en <= 1'b1;
      if (i_flush) begin
        r_pc <= i_flush_pc;
      end else if (i_stall) begin
        r_pc <= r_pc;
      end else if (i_branch) begin
        r_pc <= i_branch_target;
      end else if (r_fetch_en) begin
        r_pc <= r_pc + INST_STEP;
      end
    end
  end

  assign o_pc       = r_pc;
  assign o_fetch_en = r_fetch_en;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: drives the instruction bus and holds the IF/ID register.
module if_stage
  import project_types::*;
(
  input  logic            clk,
  input  logic            rst,
  i_instbus.master        ibus,
  input  logic            stall_i,
  input  logic            branch_i,
  input  logic [31:0]     branch_target_i,
  input  logic            flush_i,
  input  logic [31:0]     flush_pc_i,
  output logic [31:0]     id_pc_o,
  output logic [31:0]     id_inst_o,
  output logic            id_valid_o,
  output logic            id_adel_o
);

  inst_addr_t w_pc;
  logic       w_fetch_en;
  logic       w_misaligned;
  ifid_t      r_ifid;

  pc_reg u_pc_reg (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_stall         (stall_i),
    .i_branch        (branch_i),
    .i_branch_target (branch_target_i),
    .i_flush         (flush_i),
    .i_flush_pc      (flush_pc_i),
    .o_pc            (w_pc),
    .o_fetch_en      (w_fetch_en)
  );

  assign w_misaligned = is_misaligned(w_pc);

  // Bus controls come only from registered PC state, never from returned data.
  assign ibus.addr = w_pc;
  assign ibus.ce   = w_fetch_en & ~w_misaligned;

  // IF/ID register: reset/flush insert a bubble, stall holds, otherwise capture the fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ifid <= IFID_BUBBLE;
    end else if (flush_i) begin
      r_ifid <= IFID_BUBBLE;
    end else if (!stall_i) begin
      // With fetch disabled the bus data is meaningless, so a full bubble is captured.
      if (!w_fetch_en) begin
        r_ifid <= IFID_BUBBLE;
      end else if (w_misaligned) begin
        r_ifid <= '{pc: w_pc, inst: NOP_INST, valid: 1'b1, adel: 1'b1};
      end else begin
        r_ifid <= '{pc: w_pc, inst: ibus.data, valid: 1'b1, adel: 1'b0};
      end
    end
  end

  assign id_pc_o    = r_ifid.pc;
  assign id_inst_o  = r_ifid.inst;
  assign id_valid_o = r_ifid.valid;
  assign id_adel_o  = r_ifid.adel;

endmodule

// File: tb/tb_if_stage.sv
// Directed vector bench for if_stage with a combinational instruction memory model.
module tb_if_stage;

  localparam logic [31:0] B   = 32'hBFC0_0000;
  localparam logic [31:0] KEY = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        rst, stall_i, branch_i, flush_i;
  logic [31:0] branch_target_i, flush_pc_i;
  logic [31:0] id_pc_o, id_inst_o;
  logic        id_valid_o, id_adel_o;

  int n_tests = 0;
  int n_fail  = 0;

  i_instbus bus ();

  // Memory model: each word's contents are its address XOR a fixed key.
  assign bus.data = bus.addr ^ KEY;

  if_stage dut (
    .clk             (clk),
    .rst             (rst),
    .ibus            (bus),
    .stall_i         (stall_i),
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i),
    .flush_i         (flush_i),
    .flush_pc_i      (flush_pc_i),
    .id_pc_o         (id_pc_o),
    .id_inst_o       (id_inst_o),
    .id_valid_o      (id_valid_o),
    .id_adel_o       (id_adel_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stall, branch;
    logic [31:0] target;
    logic        flush;
    logic [31:0] fpc;
    logic        ce;
    logic [31:0] addr, idpc, idinst;
    logic        valid, adel;
  } vec_t;

  vec_t tv [22];

  function automatic logic [31:0] fd(input logic [31:0] a);
    return a ^ KEY;
  endfunction

  function automatic vec_t mk(input logic r, input logic s, input logic b, input logic [31:0] t,
                              input logic f, input logic [31:0] fp, input logic ce,
                              input logic [31:0] a, input logic [31:0] ip, input logic [31:0] ii,
                              input logic v, input logic ad);
    vec_t x;
    x.rst = r; x.stall = s; x.branch = b; x.target = t; x.flush = f; x.fpc = fp;
    x.ce = ce; x.addr = a; x.idpc = ip; x.idinst = ii; x.valid = v; x.adel = ad;
    return x;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic b, input logic [31:0] t,
                       input logic f, input logic [31:0] fp);
    rst = r; stall_i = s; branch_i = b; branch_target_i = t; flush_i = f; flush_pc_i = fp;
  endtask

  task automatic check_all(input int idx, input logic ce, input logic [31:0] a, input logic [31:0] ip,
                           input logic [31:0] ii, input logic v, input logic ad);
    chk("ce",    idx, {31'd0, bus.ce},     {31'd0, ce});
    chk("addr",  idx, bus.addr,            a);
    chk("id_pc", idx, id_pc_o,             ip);
    chk("inst",  idx, id_inst_o,           ii);
    chk("valid", idx, {31'd0, id_valid_o}, {31'd0, v});
    chk("adel",  idx, {31'd0, id_adel_o},  {31'd0, ad});
  endtask

  initial begin
    tv[0]  = mk(1,0,0,0,0,0,              0, B,          0,          0,               0,0);
    tv[1]  = mk(0,0,0,0,0,0,              1, B,          0,          0,               0,0);
    tv[2]  = mk(0,0,0,0,0,0,              1, B+4,        B,          fd(B),           1,0);
    tv[3]  = mk(0,0,0,0,0,0,              1, B+8,        B+4,        fd(B+4),         1,0);
    tv[4]  = mk(0,1,0,0,0,0,              1, B+8,        B+4,        fd(B+4),         1,0);
    tv[5]  = mk(0,1,1,32'hDEAD_0000,0,0,  1, B+8,        B+4,        fd(B+4),         1,0);
    tv[6]  = mk(0,1,0,0,0,0,              1, B+8,        B+4,        fd(B+4),         1,0);
    tv[7]  = mk(0,0,0,0,0,0,              1, B+'h0C,     B+8,        fd(B+8),         1,0);
    tv[8]  = mk(0,0,0,0,0,0,              1, B+'h10,     B+'h0C,     fd(B+'h0C),      1,0);
    tv[9]  = mk(0,0,1,B+'h100,0,0,        1, B+'h100,    B+'h10,     fd(B+'h10),      1,0);
    tv[10] = mk(0,0,0,0,0,0,              1, B+'h104,    B+'h100,    fd(B+'h100),     1,0);
    tv[11] = mk(0,1,1,B+'h200,1,B+'h380,  1, B+'h380,    0,          0,               0,0);
    tv[12] = mk(0,0,0,0,0,0,              1, B+'h384,    B+'h380,    fd(B+'h380),     1,0);
    tv[13] = mk(0,0,1,B+'h102,0,0,        0, B+'h102,    B+'h384,    fd(B+'h384),     1,0);
    tv[14] = mk(0,0,0,0,0,0,              0, B+'h106,    B+'h102,    0,               1,1);
    tv[15] = mk(0,0,0,0,1,32'hFFFF_FFFC,  1, 32'hFFFF_FFFC, 0,       0,               0,0);
    tv[16] = mk(0,0,0,0,0,0,              1, 0,          32'hFFFF_FFFC, fd(32'hFFFF_FFFC), 1,0);
    tv[17] = mk(0,0,0,0,0,0,              1, 4,          0,          fd(0),           1,0);
    tv[18] = mk(0,1,0,0,0,0,              1, 4,          0,          fd(0),           1,0);
    tv[19] = mk(1,1,1,B+'h200,1,32'h8000_0000, 0, B,     0,          0,               0,0);
    tv[20] = mk(0,0,0,0,0,0,              1, B,          0,          0,               0,0);
    tv[21] = mk(0,0,0,0,0,0,              1, B+4,        B,          fd(B),           1,0);

    drive(1,0,0,0,0,0);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 22; i++) begin
      drive(tv[i].rst, tv[i].stall, tv[i].branch, tv[i].target, tv[i].flush, tv[i].fpc);
      @(posedge clk);
      #1;
      check_all(i, tv[i].ce, tv[i].addr, tv[i].idpc, tv[i].idinst, tv[i].valid, tv[i].adel);
    end

    // Misaligned flush target: ce drops, adel raised next cycle, held through a stall,
    // PC keeps stepping until an aligned flush recovers.
    drive(0,0,0,0,1,B+1);
    @(posedge clk); #1;
    check_all(100, 0, B+1, 0, 0, 0, 0);
    drive(0,0,0,0,0,0);
    @(posedge clk); #1;
    check_all(101, 0, B+5, B+1, 0, 1, 1);
    drive(0,1,0,0,0,0);
    @(posedge clk); #1;
    check_all(102, 0, B+5, B+1, 0, 1, 1);
    drive(0,0,0,0,1,B+'h40);
    @(posedge clk); #1;
    check_all(103, 1, B+'h40, 0, 0, 0, 0);
    drive(0,0,0,0,0,0);
    @(posedge clk); #1;
    check_all(104, 1, B+'h44, B+'h40, fd(B+'h40), 1, 0);

    // Reset held over several cycles with redirect inputs active keeps everything at reset values.
    drive(1,0,1,B+'h300,0,0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_all(200 + k, 0, B, 0, 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
